writeback_queue: RTL and testbench
==================================

# writeback_queue

Writeback buffer that is the writer side of the register file write port (WE3/A3/WD3). It accepts results from the execute/memory stages over a valid/ready handshake, queues them in order, and retires at most one per cycle into the register file. It also reports which architectural registers have writes still pending, for the decode-stage hazard/stall logic.

## Interface
- WIDTH, 32, data width; matches register file
- DEPTH, 4, queue entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept; `count != DEPTH && rst`
- in_rd  in  5  destination register
- in_data  in  WIDTH  result value
- wb_stall  in  1  register file write port unavailable this cycle
- WE3  out  1  register file write enable (registered)
- A3  out  5  register file write address (registered)
- WD3  out  WIDTH  register file write data (registered)
- chk_a, chk_b  in  5  source registers to check
- busy_a, busy_b  out  1  matching write still pending (combinational)
- count  out  $clog2(DEPTH)+1  entries currently queued

## Operation
- Circular FIFO with head/tail pointers and a count.
- Push: at an edge where `rst && in_valid && in_ready`:
  - in_rd != 0 stores {in_rd, in_data} at tail.
  - in_rd == 0 completes the handshake but stores nothing and leaves count unchanged (writes to x0 are discarded).
- Pop: at each edge with `rst && !wb_stall && count != 0`:
  - head entry is loaded into {A3, WD3} and WE3 = 1.
  - Otherwise WE3 = 0, and A3/WD3 hold their previous values.
- Push and pop in the same edge are allowed. Count is unchanged and the entries are distinct. A pop only reads entries that were present before the edge.
- Full: in_ready = 0 when count == DEPTH. There is no push at that edge, even if a pop occurs.
- Ordering is strict FIFO. Repeated writes to the same rd are all retired, and the youngest value lands last.
- busy_x = 1 when chk_x != 0 and either a valid queue entry has rd == chk_x, or (WE3 && A3 == chk_x).
- Reset (rst = 0 at an edge), including mid-operation:
  - count = 0, pointers = 0, WE3 = 0, A3 = 0, WD3 = 0.
  - Queued entries are dropped without being written.
  - in_ready = 0 while rst = 0.

## Timing
- Latency: a result accepted at edge E0 drives WE3 = 1 in the cycle after edge E1 (unstalled, empty queue). The register file commits it at edge E2.
- Throughput: 1 result per cycle, sustained.
- wb_stall is sampled at the pop edge. A stalled cycle produces WE3 = 0 in the following cycle.
- busy timing: goes high in the cycle after acceptance and stays high through the WE3 cycle of the last matching entry. It drops in the cycle after that entry's WE3 cycle.
- in_ready, busy_a and busy_b are combinational from state and the chk inputs. They do not depend on in_valid.

## Configuration
- WBQ_FWD_EN
  - **Defined:** adds outputs fwd_a_data and fwd_b_data (WIDTH). Each is the data of the youngest pending write matching chk_x, considering queue entries first and the output register second. Each is 0 when busy_x = 0. Enables decode forwarding instead of stalling.
  - **Undefined:** these ports do not exist, and no matching-priority logic is built.

## Test plan
- **Reset:** rst = 0 for 2 cycles with in_valid = 1 and in_rd = 3 -> in_ready = 0, WE3 = 0, count = 0, busy_a = 0 (chk_a = 3).
- **Single write:** rst = 1, push rd = 3, data 0x0000000F at E0 -> WE3 = 1, A3 = 3, WD3 = 0xF for exactly one cycle after E1. busy_a (chk_a = 3) = 1 from after E0 through that cycle, then 0.
- **Stall/full:** wb_stall = 1, offer rd 1, 5, 6, 7, 8 with data 0xABCD, 0xFFFF, 0x1, 0x2, 0x3 -> first four accepted, count = 4, in_ready = 0, rd 8 held. Release stall -> WE3 on four consecutive cycles with A3 = 1, 5, 6, 7 in order. Then rd 8 is accepted and retired.
- **x0 write:** push rd = 0, data 0xABCD -> handshake completes, count stays 0, WE3 never asserts, busy (chk = 0) = 0.
- **Mid-operation reset:** stall with count = 3, then rst = 0 for one edge and release stall -> count = 0 and WE3 stays 0 afterwards.
- **Forwarding (WBQ_FWD_EN defined):** under stall, push rd = 1, 0x1111 then rd = 1, 0x2222 -> busy_a = 1 and fwd_a_data = 0x2222 (chk_a = 1). After the first retires, fwd_a_data still = 0x2222.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: in-order writeback buffer that drives the register file write port (WE3/A3/WD3) and reports pending writes
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_rd/in_data producer handshake;
//   wb_stall holds retirement; WE3/A3/WD3 registered write port; chk_a/chk_b -> busy_a/busy_b
//   pending-write flags; count queue occupancy.
// Optional: define WBQ_FWD_EN to add fwd_a_data/fwd_b_data, the youngest pending value for each chk register.
module writeback_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     wb_stall,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [WIDTH-1:0]         WD3,
  input  logic [4:0]               chk_a,
  input  logic [4:0]               chk_b,
  output logic                     busy_a,
  output logic                     busy_b,
`ifdef WBQ_FWD_EN
  output logic [WIDTH-1:0]         fwd_a_data,
  output logic [WIDTH-1:0]         fwd_b_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [4:0]       q_rd   [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             push, pop;
  assign in_ready = count != CW'(DEPTH) && rst;
  // x0 writes complete the handshake but are never stored
  assign push = in_valid && in_ready && in_rd != 5'd0;
  // pop only sees entries present before the edge, so an empty queue never bypasses
  assign pop = rst && !wb_stall && count != '0;
  always_ff @(posedge clk)
    if (push) begin
      q_rd[tail]   <= in_rd;
      q_data[tail] <= in_data;
    end
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      WE3   <= 1'b0;
      A3    <= '0;
      WD3   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (pop) A3 <= q_rd[head];
      if (pop) WD3 <= q_data[head];
      WE3   <= pop;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // an entry at offset i from head is live when i < count
  function automatic logic pending(input logic [4:0] c);
    logic [PW-1:0] idx;
    pending = WE3 && A3 == c;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && q_rd[idx] == c) pending = 1'b1;
    end
    pending = pending && c != 5'd0;
  endfunction
  assign busy_a = pending(chk_a);
  assign busy_b = pending(chk_b);
`ifdef WBQ_FWD_EN
  // output register is oldest; later (younger) queue matches override it
  function automatic logic [WIDTH-1:0] youngest(input logic [4:0] c);
    logic [PW-1:0] idx;
    youngest = (WE3 && A3 == c && c != 5'd0) ? WD3 : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (c != 5'd0 && CW'(i) < count && q_rd[idx] == c) youngest = q_data[idx];
    end
  endfunction
  assign fwd_a_data = youngest(chk_a);
  assign fwd_b_data = youngest(chk_b);
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: scoreboard bench for writeback_queue with a queue-level reference model
module tb_writeback_queue;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic wb_stall = 1'b0;
  logic [4:0] in_rd = '0;
  logic [4:0] chk_a = '0;
  logic [4:0] chk_b = '0;
  logic [W-1:0] in_data = '0;
  logic in_ready, WE3, busy_a, busy_b;
  logic [4:0] A3;
  logic [W-1:0] WD3;
  logic [CW-1:0] count;
`ifdef WBQ_FWD_EN
  logic [W-1:0] fwd_a_data, fwd_b_data;
`endif
  writeback_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .wb_stall(wb_stall), .WE3(WE3), .A3(A3), .WD3(WD3),
    .chk_a(chk_a), .chk_b(chk_b), .busy_a(busy_a), .busy_b(busy_b),
`ifdef WBQ_FWD_EN
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
`endif
    .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] d;
  } ent_t;
  int tests = 0;
  int fails = 0;
  ent_t mq[$];
  ent_t sb[$];
  bit m_we = 1'b0;
  logic [4:0] m_rd = '0;
  logic [W-1:0] m_d = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit exp_busy(input logic [4:0] c);
    if (c == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
    return m_we && m_rd == c;
  endfunction
  function automatic logic [W-1:0] exp_fwd(input logic [4:0] c);
    logic [W-1:0] r;
    r = '0;
    if (c == 0) return r;
    if (m_we && m_rd == c) r = m_d;
    foreach (mq[i]) if (mq[i].rd == c) r = mq[i].d;
    return r;
  endfunction
  // reference model: a bounded FIFO of pending writes plus one retired slot
  always @(posedge clk) begin
    ent_t e;
    bit ready;
    if (!rst) begin
      mq.delete();
      sb.delete();
      m_we = 1'b0;
      m_rd = '0;
      m_d = '0;
    end else begin
      ready = mq.size() < D;
      if (!wb_stall && mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1;
        m_rd = e.rd;
        m_d = e.d;
      end else m_we = 1'b0;
      if (in_valid && ready && in_rd != 0) begin
        e.rd = in_rd;
        e.d = in_data;
        mq.push_back(e);
        sb.push_back(e);
      end
    end
  end
  // monitor: retire order via scoreboard, plus per-cycle status checks
  always @(negedge clk) begin
    ent_t e;
    chk("we3", WE3, m_we);
    chk("a3", A3, m_rd);
    chk("wd3", WD3, m_d);
    if (WE3 === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL retire: WE3 with A3=%0d WD3=%0h but nothing expected", A3, WD3);
      end else begin
        e = sb.pop_front();
        chk("sb_a3", A3, e.rd);
        chk("sb_wd3", WD3, e.d);
      end
    end
    chk("in_ready", in_ready, rst && mq.size() < D);
    chk("count", count, mq.size());
    chk("busy_a", busy_a, exp_busy(chk_a));
    chk("busy_b", busy_b, exp_busy(chk_b));
`ifdef WBQ_FWD_EN
    chk("fwd_a", fwd_a_data, exp_fwd(chk_a));
    chk("fwd_b", fwd_b_data, exp_fwd(chk_b));
`endif
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [4:0] rd, input logic [W-1:0] d);
    int n;
    in_valid = 1'b1;
    in_rd = rd;
    in_data = d;
    n = 0;
    while (!in_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 for rd %0d", rd);
    end
    step(1);
    in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    in_valid = 1'b1;
    in_rd = 5'd3;
    chk_a = 5'd3;
    step(2);
    chk("rst_ready", in_ready, 0);
    chk("rst_we3", WE3, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy_a, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step(1);
    push(5'd3, 32'hF);
    chk("single_busy_e0", busy_a, 1);
    step(1);
    chk("single_we", WE3, 1);
    chk("single_a3", A3, 3);
    chk("single_wd3", WD3, 32'hF);
    chk("single_busy_we", busy_a, 1);
    step(1);
    chk("single_we_off", WE3, 0);
    chk("single_busy_off", busy_a, 0);
    wb_stall = 1'b1;
    push(5'd1, 32'hABCD);
    push(5'd5, 32'hFFFF);
    push(5'd6, 32'h1);
    push(5'd7, 32'h2);
    chk("full_count", count, 4);
    in_valid = 1'b1;
    in_rd = 5'd8;
    in_data = 32'h3;
    step(2);
    chk("full_ready", in_ready, 0);
    chk("full_hold", count, 4);
    wb_stall = 1'b0;
    push(5'd8, 32'h3);
    step(8);
    chk("drain1", count, 0);
    push(5'd0, 32'hABCD);
    chk("x0_count", count, 0);
    chk_a = 5'd0;
    chk("x0_busy", busy_a, 0);
    step(3);
    wb_stall = 1'b1;
    push(5'd2, 32'h22);
    push(5'd9, 32'h99);
    push(5'd4, 32'h44);
    chk("mid_count", count, 3);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    wb_stall = 1'b0;
    chk("mid_rst_count", count, 0);
    step(4);
    chk("mid_after", count, 0);
`ifdef WBQ_FWD_EN
    wb_stall = 1'b1;
    chk_a = 5'd1;
    push(5'd1, 32'h1111);
    push(5'd1, 32'h2222);
    chk("fwd_busy", busy_a, 1);
    chk("fwd_young", fwd_a_data, 32'h2222);
    wb_stall = 1'b0;
    step(1);
    chk("fwd_after_pop", fwd_a_data, 32'h2222);
    step(4);
`endif
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_rd = 5'($urandom_range(0, 7));
      in_data = $urandom;
      wb_stall = $urandom_range(0, 9) < 4;
      chk_a = 5'($urandom_range(0, 7));
      chk_b = 5'($urandom_range(0, 7));
      rst = $urandom_range(0, 99) != 0;
      step(1);
    end
    in_valid = 1'b0;
    wb_stall = 1'b0;
    rst = 1'b1;
    step(10);
    chk("final_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
